// File: rtl/trig_pulse_tx.sv
// Trigger transmitter: per-channel fire/dead-time pulse shapers plus a fixed-phase calibration train.
// Optional TRIG_TX_RETRIGGER_EN: trig_in during FIRE reloads the high-time counter.
module trig_pulse_tx #(
  parameter int unsigned NCH     = 16,
  parameter int unsigned CAL_WIN = 216
) (
  input  logic           clk_adc,
  input  logic           rst,
  input  logic [NCH-1:0] trig_in,
  input  logic [7:0]     firingticks,
  input  logic [7:0]     deadticks,
  input  logic           cal_start,
  input  logic [1:0]     cal_phase,
  input  logic [NCH-1:0] cal_mask,
  output logic [NCH-1:0] coax_out,
  output logic [NCH-1:0] busy,
  output logic           cal_active,
  output logic           cal_done
);

  localparam int unsigned WinW = (CAL_WIN > 1) ? $clog2(CAL_WIN) : 1;

  typedef enum logic [1:0] {StIdle, StFire, StDead} ch_state_e;

  ch_state_e      state_q [NCH];
  ch_state_e      state_d [NCH];
  logic [7:0]     cnt_q   [NCH];
  logic [7:0]     cnt_d   [NCH];
  logic [NCH-1:0] coax_q, coax_d;
  logic [1:0]     phase_q, phase_d;
  logic           cal_active_q, cal_active_d;
  logic           cal_done_q, cal_done_d;
  logic [WinW-1:0] win_q, win_d;
  logic [1:0]     cal_phase_q, cal_phase_d;
  logic [NCH-1:0] cal_mask_q, cal_mask_d;
  logic           cal_accept;
  logic [NCH-1:0] force_idle;
  logic [7:0]     fire_len;

  assign fire_len = (firingticks == 8'd0) ? 8'd1 : firingticks;
  assign phase_d  = phase_q + 2'd1;

  always_comb begin
    cal_accept   = cal_start && !cal_active_q;
    cal_active_d = cal_active_q;
    cal_done_d   = 1'b0;
    win_d        = win_q;
    cal_phase_d  = cal_phase_q;
    cal_mask_d   = cal_mask_q;
    if (cal_accept) begin
      cal_active_d = 1'b1;
      win_d        = '0;
      cal_phase_d  = cal_phase;
      cal_mask_d   = cal_mask;
    end else if (cal_active_q) begin
      if (win_q == WinW'(CAL_WIN - 1)) begin
        cal_active_d = 1'b0;
        cal_done_d   = 1'b1;
      end else begin
        win_d = win_q + WinW'(1);
      end
    end
    // Held through the window's last cycle so masked triggers resume only after cal_done.
    force_idle = (cal_active_q ? cal_mask_q : '0) | (cal_accept ? cal_mask : '0);
  end

  always_comb begin
    coax_d = '0;
    for (int i = 0; i < NCH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      if (force_idle[i]) begin
        state_d[i] = StIdle;
        cnt_d[i]   = 8'd0;
      end else begin
        unique case (state_q[i])
          StIdle: begin
            if (trig_in[i]) begin
              state_d[i] = StFire;
              cnt_d[i]   = fire_len;
            end
          end
          StFire: begin
`ifdef TRIG_TX_RETRIGGER_EN
            if (trig_in[i]) begin
              cnt_d[i] = fire_len;
            end else if (cnt_q[i] == 8'd1) begin
              state_d[i] = (deadticks != 8'd0) ? StDead : StIdle;
              cnt_d[i]   = deadticks;
            end else begin
              cnt_d[i] = cnt_q[i] - 8'd1;
            end
`else
            if (cnt_q[i] == 8'd1) begin
              state_d[i] = (deadticks != 8'd0) ? StDead : StIdle;
              cnt_d[i]   = deadticks;
            end else begin
              cnt_d[i] = cnt_q[i] - 8'd1;
            end
`endif
          end
          StDead: begin
            if (cnt_q[i] == 8'd1) begin
              state_d[i] = StIdle;
              cnt_d[i]   = 8'd0;
            end else begin
              cnt_d[i] = cnt_q[i] - 8'd1;
            end
          end
          default: begin
            state_d[i] = StIdle;
            cnt_d[i]   = 8'd0;
          end
        endcase
      end
      coax_d[i] = (cal_active_d && cal_mask_d[i]) ? (phase_d == cal_phase_d)
                                                   : (state_d[i] == StFire);
    end
  end

  always_ff @(posedge clk_adc) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        state_q[i] <= StIdle;
        cnt_q[i]   <= 8'd0;
      end
      coax_q       <= '0;
      phase_q      <= 2'd0;
      cal_active_q <= 1'b0;
      cal_done_q   <= 1'b0;
      win_q        <= '0;
      cal_phase_q  <= 2'd0;
      cal_mask_q   <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      coax_q       <= coax_d;
      phase_q      <= phase_d;
      cal_active_q <= cal_active_d;
      cal_done_q   <= cal_done_d;
      win_q        <= win_d;
      cal_phase_q  <= cal_phase_d;
      cal_mask_q   <= cal_mask_d;
    end
  end

  always_comb begin
    busy = '0;
    for (int i = 0; i < NCH; i++) begin
      busy[i] = (state_q[i] != StIdle);
    end
  end

  assign coax_out   = coax_q;
  assign cal_active = cal_active_q;
  assign cal_done   = cal_done_q;

endmodule
